// File: rtl/gpio_host_pkg.sv
// gpio_host_pkg
// Shared definitions for the host-side GPIO streaming link:
//   - command op encodings (LOAD / RUN / SEND / reserved)
//   - link state enumeration
//   - default parameter values for the link top
// No ports; imported by gpio_host_link.
package gpio_host_pkg;

    localparam int DEFAULT_WORD_W      = 11;
    localparam int DEFAULT_CNT_W       = 16;
    localparam int DEFAULT_TIMEOUT_CYC = 65535;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_RUN  = 2'd1,
        OP_SEND = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PULSE      = 3'd1,
        ST_STREAM_IN  = 3'd2,
        ST_STREAM_OUT = 3'd3,
        ST_WAIT_DONE  = 3'd4,
        ST_RESP       = 3'd5
    } state_e;

    // True for ops that move words through the chip FIFOs.
    function automatic logic op_streams(input op_e op);
        return (op == OP_LOAD) || (op == OP_SEND);
    endfunction

endpackage

// File: rtl/gpio_host_link.sv
// gpio_host_link
// Host-side driver for the accelerator GPIO streaming port, running in the
// io_clk domain. Accepts LOAD / RUN / SEND commands, pulses the matching
// chip strobe, streams words into the chip input FIFO (LOAD) or out of the
// chip output FIFO (SEND), waits for the chip's done level to rise and then
// returns a one-cycle response.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o     command handshake, cmd_op_i, cmd_len_i
//   src_valid_i / src_ready_o     source words (src_data_i) for LOAD
//   snk_valid_o / snk_ready_i     drained words (snk_data_o) for SEND
//   rsp_valid_o, rsp_err_o,       one-cycle response with error flag and
//   rsp_count_o                   number of words moved
//   busy_o                        high whenever the link is not idle
//   in_fifo_*                     chip input FIFO write side
//   out_fifo_*                    chip output FIFO read side
//   load_kdtree_o, fsm_start_o,   one-cycle control strobes to the chip
//   send_best_arr_o
//   load_done_i, fsm_done_i,      level done indications from the chip
//   send_done_i
module gpio_host_link
    import gpio_host_pkg::*;
#(
    parameter int WORD_W      = DEFAULT_WORD_W,
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [CNT_W-1:0]  cmd_len_i,

    input  logic              src_valid_i,
    output logic              src_ready_o,
    input  logic [WORD_W-1:0] src_data_i,

    output logic              snk_valid_o,
    input  logic              snk_ready_i,
    output logic [WORD_W-1:0] snk_data_o,

    output logic              rsp_valid_o,
    output logic              rsp_err_o,
    output logic [CNT_W-1:0]  rsp_count_o,
    output logic              busy_o,

    output logic              in_fifo_wenq_o,
    output logic [WORD_W-1:0] in_fifo_wdata_o,
    input  logic              in_fifo_wfull_n_i,

    output logic              out_fifo_deq_o,
    input  logic [WORD_W-1:0] out_fifo_rdata_i,
    input  logic              out_fifo_rempty_n_i,

    output logic              load_kdtree_o,
    output logic              fsm_start_o,
    output logic              send_best_arr_o,

    input  logic              load_done_i,
    input  logic              fsm_done_i,
    input  logic              send_done_i
);

    // TIMEOUT_CYC - 1 is the last timer value spent in WAIT_DONE.
    localparam logic [31:0] TMR_LAST = 32'(TIMEOUT_CYC - 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               done_seen_q, done_seen_d;
    logic [31:0]        timer_q, timer_d;

    logic               rsp_valid_q, busy_q;
    logic               load_kdtree_q, fsm_start_q, send_best_arr_q;

    logic               cmd_accept;
    op_e                cmd_op;
    logic               words_left;
    logic               in_xfer, out_xfer, xfer;
    logic               done_sel, done_rise;
    logic               done_window;
    logic               timeout_hit;

    assign cmd_op     = op_e'(cmd_op_i);
    assign cmd_accept = cmd_valid_i && (state_q == ST_IDLE);
    assign words_left = (remaining_q != '0);

    // Done level selected by the latched op. done_q tracks it every cycle,
    // so a level that is already high when an op starts never looks like a
    // rise once the first post-PULSE cycle has been registered.
    always_comb begin
        case (op_q)
            OP_LOAD: done_sel = load_done_i;
            OP_RUN:  done_sel = fsm_done_i;
            OP_SEND: done_sel = send_done_i;
            default: done_sel = 1'b0;
        endcase
    end

    assign done_rise   = done_sel && !done_q;
    // During PULSE done_q still reflects the previous op's selection, so
    // rises are only trusted from the following cycle onward.
    assign done_window = (state_q == ST_STREAM_IN) || (state_q == ST_STREAM_OUT) ||
                         (state_q == ST_WAIT_DONE);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (state_q == ST_WAIT_DONE) &&
                         (timer_q == TMR_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    state_d = (cmd_op == OP_RSVD) ? ST_RESP : ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (op_streams(op_q) && words_left) begin
                    state_d = (op_q == OP_LOAD) ? ST_STREAM_IN : ST_STREAM_OUT;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_STREAM_IN,
            ST_STREAM_OUT: begin
                if (xfer && (remaining_q == CNT_W'(1))) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // A rise on the current edge counts, so RESP follows the
                // sampling edge directly.
                if (done_seen_q || done_rise || timeout_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: combinational outputs (FIFO handshakes)
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready_o     = (state_q == ST_IDLE);
        in_xfer         = (state_q == ST_STREAM_IN) && src_valid_i &&
                          in_fifo_wfull_n_i && words_left;
        snk_valid_o     = (state_q == ST_STREAM_OUT) && out_fifo_rempty_n_i && words_left;
        out_xfer        = snk_valid_o && snk_ready_i;
        src_ready_o     = in_xfer;
        in_fifo_wenq_o  = in_xfer;
        in_fifo_wdata_o = src_data_i;
        out_fifo_deq_o  = out_xfer;
        snk_data_o      = out_fifo_rdata_i;
        xfer            = in_xfer || out_xfer;
    end

    // ------------------------------------------------------------------
    // Command, counter, done and timeout bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        op_d        = op_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        err_d       = err_q;
        done_seen_d = done_seen_q;
        done_d      = done_sel;
        timer_d     = (state_q == ST_WAIT_DONE) ? (timer_q + 32'd1) : 32'd0;

        if (cmd_accept) begin
            op_d        = cmd_op;
            remaining_d = cmd_len_i;
            count_d     = '0;
            err_d       = (cmd_op == OP_RSVD);
            done_seen_d = 1'b0;
        end

        if (xfer) begin
            remaining_d = remaining_q - CNT_W'(1);
            count_d     = count_q + CNT_W'(1);
        end

        if (done_window && done_rise) begin
            done_seen_d = 1'b1;
        end

        // Timeout only flags an error when no done arrived in the same cycle.
        if (timeout_hit && !done_seen_q && !done_rise) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q            <= OP_LOAD;
            remaining_q     <= '0;
            count_q         <= '0;
            err_q           <= 1'b0;
            done_q          <= 1'b0;
            done_seen_q     <= 1'b0;
            timer_q         <= 32'd0;
            rsp_valid_q     <= 1'b0;
            busy_q          <= 1'b0;
            load_kdtree_q   <= 1'b0;
            fsm_start_q     <= 1'b0;
            send_best_arr_q <= 1'b0;
        end else begin
            op_q            <= op_d;
            remaining_q     <= remaining_d;
            count_q         <= count_d;
            err_q           <= err_d;
            done_q          <= done_d;
            done_seen_q     <= done_seen_d;
            timer_q         <= timer_d;
            // Registered outputs are computed from the next state so they
            // line up with the state they describe.
            rsp_valid_q     <= (state_d == ST_RESP);
            busy_q          <= (state_d != ST_IDLE);
            load_kdtree_q   <= (state_d == ST_PULSE) && (op_d == OP_LOAD);
            fsm_start_q     <= (state_d == ST_PULSE) && (op_d == OP_RUN);
            send_best_arr_q <= (state_d == ST_PULSE) && (op_d == OP_SEND);
        end
    end

    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_err_o       = err_q;
    assign rsp_count_o     = count_q;
    assign busy_o          = busy_q;
    assign load_kdtree_o   = load_kdtree_q;
    assign fsm_start_o     = fsm_start_q;
    assign send_best_arr_o = send_best_arr_q;

endmodule

// File: tb/tb_gpio_host_link.sv
// tb_gpio_host_link
// Directed bench for gpio_host_link. Inputs change on the falling edge and
// outputs are sampled shortly after it, away from the rising edge.
module tb_gpio_host_link;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_len;
    logic        src_valid, src_ready;
    logic [10:0] src_data;
    logic        snk_valid, snk_ready;
    logic [10:0] snk_data;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_count;
    logic        busy;
    logic        in_fifo_wenq, in_fifo_wfull_n;
    logic [10:0] in_fifo_wdata;
    logic        out_fifo_deq, out_fifo_rempty_n;
    logic [10:0] out_fifo_rdata;
    logic        load_kdtree, fsm_start, send_best_arr;
    logic        load_done, fsm_done, send_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio_host_link #(.WORD_W(11), .CNT_W(16), .TIMEOUT_CYC(16)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .cmd_valid_i        (cmd_valid),
        .cmd_ready_o        (cmd_ready),
        .cmd_op_i           (cmd_op),
        .cmd_len_i          (cmd_len),
        .src_valid_i        (src_valid),
        .src_ready_o        (src_ready),
        .src_data_i         (src_data),
        .snk_valid_o        (snk_valid),
        .snk_ready_i        (snk_ready),
        .snk_data_o         (snk_data),
        .rsp_valid_o        (rsp_valid),
        .rsp_err_o          (rsp_err),
        .rsp_count_o        (rsp_count),
        .busy_o             (busy),
        .in_fifo_wenq_o     (in_fifo_wenq),
        .in_fifo_wdata_o    (in_fifo_wdata),
        .in_fifo_wfull_n_i  (in_fifo_wfull_n),
        .out_fifo_deq_o     (out_fifo_deq),
        .out_fifo_rdata_i   (out_fifo_rdata),
        .out_fifo_rempty_n_i(out_fifo_rempty_n),
        .load_kdtree_o      (load_kdtree),
        .fsm_start_o        (fsm_start),
        .send_best_arr_o    (send_best_arr),
        .load_done_i        (load_done),
        .fsm_done_i         (fsm_done),
        .send_done_i        (send_done)
    );

    // Presents one command for one cycle; starts and ends on a falling edge.
    task automatic issue_cmd(input logic [1:0] op, input logic [15:0] len);
        cmd_op    = op;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        logic [10:0] flags;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 16'd0;
        src_valid = 1'b0; src_data = 11'd0; snk_ready = 1'b0;
        in_fifo_wfull_n = 1'b1; out_fifo_rempty_n = 1'b0; out_fifo_rdata = 11'd0;
        load_done = 1'b0; fsm_done = 1'b0; send_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        flags = {cmd_ready, busy, rsp_valid, rsp_err, load_kdtree, fsm_start,
                 send_best_arr, in_fifo_wenq, out_fifo_deq, src_ready, snk_valid};
        checks++;
        if (flags !== 11'b100_0000_0000) begin
            errors++; $display("FAIL reset_flags got=%b exp=%b", flags, 11'b100_0000_0000);
        end
        checks++;
        if (rsp_count !== 16'd0) begin
            errors++; $display("FAIL reset_count got=%0d exp=0", rsp_count);
        end
        $display("reset: flags=%b count=%0d", flags, rsp_count);
    endtask

    task automatic test_load;
        int  sent = 0;
        int  k = 0;
        int  nwenq = 0;
        logic exp;
        issue_cmd(2'd0, 16'd5);
        checks++;
        if ({load_kdtree, fsm_start, send_best_arr, in_fifo_wenq} !== 4'b1000) begin
            errors++; $display("FAIL load_pulse got=%b exp=1000",
                               {load_kdtree, fsm_start, send_best_arr, in_fifo_wenq});
        end
        @(negedge clk);
        while (sent < 5 && k < 20) begin
            src_valid = 1'b1;
            src_data = 11'(sent + 1);
            in_fifo_wfull_n = !(k == 2 || k == 3);
            #1;
            exp = in_fifo_wfull_n;
            if (in_fifo_wenq === 1'b1) nwenq++;
            checks++;
            if (in_fifo_wenq !== exp || src_ready !== exp) begin
                errors++; $display("FAIL load_wenq k=%0d got=%b/%b exp=%b",
                                   k, in_fifo_wenq, src_ready, exp);
            end
            if (exp) begin
                checks++;
                if (in_fifo_wdata !== 11'(sent + 1)) begin
                    errors++; $display("FAIL load_wdata got=%h exp=%h", in_fifo_wdata, 11'(sent + 1));
                end
                $display("load: word %0d data=%h", sent, in_fifo_wdata);
                sent++;
            end
            checks++;
            if (load_kdtree !== 1'b0) begin
                errors++; $display("FAIL load_strobe_len got=%b exp=0", load_kdtree);
            end
            k++;
            @(negedge clk);
        end
        checks++;
        if (k != 7) begin
            errors++; $display("FAIL load_cycles got=%0d exp=7", k);
        end
        // First WAIT_DONE cycle: stream closed, raise done.
        src_valid = 1'b0;
        in_fifo_wfull_n = 1'b1;
        #1;
        checks++;
        if ({in_fifo_wenq, busy, rsp_valid} !== 3'b010) begin
            errors++; $display("FAIL load_wait got=%b exp=010", {in_fifo_wenq, busy, rsp_valid});
        end
        load_done = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_count !== 16'd5) begin
            errors++; $display("FAIL load_rsp got=%b/%b/%0d exp=1/0/5", rsp_valid, rsp_err, rsp_count);
        end
        $display("load: rsp valid=%b err=%b count=%0d", rsp_valid, rsp_err, rsp_count);
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_count !== 16'd5) begin
            errors++; $display("FAIL load_idle got=%b/%b/%b/%0d exp=0/1/0/5",
                               rsp_valid, cmd_ready, busy, rsp_count);
        end
        checks++;
        if (nwenq != 5) begin
            errors++; $display("FAIL load_wenq_total got=%0d exp=5", nwenq);
        end
        load_done = 1'b0;
    endtask

    task automatic test_send;
        int  recv = 0;
        int  k = 0;
        logic exp_v, exp_d;
        issue_cmd(2'd2, 16'd4);
        checks++;
        if ({load_kdtree, fsm_start, send_best_arr, out_fifo_deq} !== 4'b0010) begin
            errors++; $display("FAIL send_pulse got=%b exp=0010",
                               {load_kdtree, fsm_start, send_best_arr, out_fifo_deq});
        end
        @(negedge clk);
        while (recv < 4 && k < 30) begin
            out_fifo_rempty_n = (k % 3 != 1);
            snk_ready = (k % 4 != 2);
            out_fifo_rdata = 11'h100 + 11'(k);
            #1;
            exp_v = out_fifo_rempty_n;
            exp_d = exp_v && snk_ready;
            checks++;
            if (snk_valid !== exp_v || out_fifo_deq !== exp_d) begin
                errors++; $display("FAIL send_hs k=%0d got=%b/%b exp=%b/%b",
                                   k, snk_valid, out_fifo_deq, exp_v, exp_d);
            end
            if (exp_d) begin
                checks++;
                if (snk_data !== 11'h100 + 11'(k)) begin
                    errors++; $display("FAIL send_data got=%h exp=%h", snk_data, 11'h100 + 11'(k));
                end
                $display("send: word %0d data=%h", recv, snk_data);
                recv++;
            end
            k++;
            @(negedge clk);
        end
        checks++;
        if (k != 9) begin
            errors++; $display("FAIL send_cycles got=%0d exp=9", k);
        end
        out_fifo_rempty_n = 1'b1;
        snk_ready = 1'b1;
        #1;
        checks++;
        if (out_fifo_deq !== 1'b0 || snk_valid !== 1'b0) begin
            errors++; $display("FAIL send_closed got=%b/%b exp=0/0", out_fifo_deq, snk_valid);
        end
        send_done = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_count !== 16'd4) begin
            errors++; $display("FAIL send_rsp got=%b/%b/%0d exp=1/0/4", rsp_valid, rsp_err, rsp_count);
        end
        $display("send: rsp valid=%b err=%b count=%0d", rsp_valid, rsp_err, rsp_count);
        @(negedge clk);
        send_done = 1'b0;
        out_fifo_rempty_n = 1'b0;
        snk_ready = 1'b0;
    endtask

    task automatic test_reserved;
        issue_cmd(2'd3, 16'd7);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_count !== 16'd0) begin
            errors++; $display("FAIL rsvd_rsp got=%b/%b/%0d exp=1/1/0", rsp_valid, rsp_err, rsp_count);
        end
        checks++;
        if ({load_kdtree, fsm_start, send_best_arr} !== 3'b000) begin
            errors++; $display("FAIL rsvd_strobe got=%b exp=000", {load_kdtree, fsm_start, send_best_arr});
        end
        $display("rsvd: rsp valid=%b err=%b count=%0d", rsp_valid, rsp_err, rsp_count);
        @(negedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b1) begin
            errors++; $display("FAIL rsvd_idle got=%b/%b/%b exp=1/0/1", cmd_ready, rsp_valid, rsp_err);
        end
    endtask

    task automatic test_run_stale;
        int early = 0;
        fsm_done = 1'b1;
        @(negedge clk);
        issue_cmd(2'd1, 16'd9);
        checks++;
        if ({load_kdtree, fsm_start, send_best_arr} !== 3'b010) begin
            errors++; $display("FAIL run_pulse got=%b exp=010", {load_kdtree, fsm_start, send_best_arr});
        end
        repeat (5) begin
            @(negedge clk); #1;
            if (rsp_valid === 1'b1) early++;
        end
        checks++;
        if (early != 0 || busy !== 1'b1) begin
            errors++; $display("FAIL run_stale got=%0d responses busy=%b exp=0 busy=1", early, busy);
        end
        fsm_done = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL run_fall got=%b exp=0", rsp_valid);
        end
        fsm_done = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_count !== 16'd0) begin
            errors++; $display("FAIL run_rsp got=%b/%b/%0d exp=1/0/0", rsp_valid, rsp_err, rsp_count);
        end
        $display("run: rsp valid=%b err=%b count=%0d", rsp_valid, rsp_err, rsp_count);
        @(negedge clk);
        fsm_done = 1'b0;
    endtask

    task automatic test_timeout;
        int n = 0;
        issue_cmd(2'd1, 16'd0);
        @(negedge clk); #1;
        while (rsp_valid !== 1'b1 && n < 40) begin
            n++;
            @(negedge clk); #1;
        end
        checks++;
        if (n != 16) begin
            errors++; $display("FAIL timeout_cycles got=%0d exp=16", n);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_count !== 16'd0) begin
            errors++; $display("FAIL timeout_rsp got=%b/%b/%0d exp=1/1/0", rsp_valid, rsp_err, rsp_count);
        end
        $display("timeout: wait=%0d err=%b", n, rsp_err);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        issue_cmd(2'd0, 16'd6);
        @(negedge clk);
        in_fifo_wfull_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src_valid = 1'b1;
            src_data = 11'h010 + 11'(i);
            #1;
            checks++;
            if (in_fifo_wenq !== 1'b1 || in_fifo_wdata !== 11'h010 + 11'(i)) begin
                errors++; $display("FAIL mid_wenq i=%0d got=%b/%h exp=1/%h",
                                   i, in_fifo_wenq, in_fifo_wdata, 11'h010 + 11'(i));
            end
            if (i < 2) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_fifo_wenq, src_ready, load_kdtree, busy, cmd_ready} !== 5'b00001 ||
            rsp_count !== 16'd0) begin
            errors++; $display("FAIL mid_reset got=%b/%0d exp=00001/0",
                               {in_fifo_wenq, src_ready, load_kdtree, busy, cmd_ready}, rsp_count);
        end
        $display("mid reset: wenq=%b busy=%b", in_fifo_wenq, busy);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        src_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || in_fifo_wenq !== 1'b0) begin
            errors++; $display("FAIL mid_idle got=%b/%b/%b exp=1/0/0", cmd_ready, busy, in_fifo_wenq);
        end
        issue_cmd(2'd1, 16'd0);
        checks++;
        if (fsm_start !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_new_cmd got=%b/%b exp=1/1", fsm_start, busy);
        end
        @(negedge clk);
        fsm_done = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_count !== 16'd0) begin
            errors++; $display("FAIL mid_rsp got=%b/%b/%0d exp=1/0/0", rsp_valid, rsp_err, rsp_count);
        end
        $display("mid reset: new run rsp valid=%b err=%b", rsp_valid, rsp_err);
        @(negedge clk);
        fsm_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_send();
        test_reserved();
        test_run_stale();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gpio_host_link.md
# gpio_host_link

Host-side counterpart of the accelerator's GPIO streaming port, clocked by the same `io_clk` that feeds the chip. It accepts high-level commands (load, run, send-results), pulses the matching control strobe, pushes source words into the chip's input FIFO, and drains the chip's output FIFO. It then waits for the chip's done indication and returns a one-cycle response. It is used in FPGA bring-up harnesses and as the reusable driver in system testbenches.

## Interface
- `WORD_W`, 11: GPIO FIFO word width.
- `CNT_W`, 16: width of `cmd_len` and `rsp_count`.
- `TIMEOUT_CYC`, 65535: max cycles in WAIT_DONE; 0 disables the timeout.

- `clk` in 1: the `io_clk` domain. One clock only.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_op` in 2: 0 LOAD, 1 RUN, 2 SEND, 3 reserved.
- `cmd_len` in CNT_W: words to move. Ignored for RUN.
- `src_valid` in 1, `src_ready` out 1, `src_data` in WORD_W: words to push into the chip.
- `snk_valid` out 1, `snk_ready` in 1, `snk_data` out WORD_W: words drained from the chip.
- `rsp_valid` out 1: one-cycle pulse.
- `rsp_err` out 1: timeout or reserved op.
- `rsp_count` out CNT_W: words moved.
- `busy` out 1: high whenever not IDLE.
- `in_fifo_wenq` out 1, `in_fifo_wdata` out WORD_W, `in_fifo_wfull_n` in 1: chip input FIFO.
- `out_fifo_deq` out 1, `out_fifo_rdata` in WORD_W, `out_fifo_rempty_n` in 1: chip output FIFO.
- `load_kdtree`, `fsm_start`, `send_best_arr` out 1: control strobes to the chip.
- `load_done`, `fsm_done`, `send_done` in 1: level done indications from the chip.

## Operation
- States:
  - IDLE: `cmd_ready` = 1.
  - PULSE: the strobe for `cmd_op` is high.
  - STREAM_IN: used by LOAD.
  - STREAM_OUT: used by SEND.
  - WAIT_DONE.
  - RESP.
- IDLE → PULSE on accept (`cmd_valid & cmd_ready`). Op and len are latched; `rsp_count` is cleared.
- Reserved op goes IDLE → RESP directly, with `rsp_err` = 1 and no strobe.
- Exit from PULSE:
  - LOAD → STREAM_IN.
  - SEND → STREAM_OUT.
  - RUN → WAIT_DONE.
  - If `cmd_len` = 0, LOAD/SEND skip straight to WAIT_DONE.
- STREAM_IN (all combinational):
  - `in_fifo_wenq` = `src_ready` = `src_valid & in_fifo_wfull_n & (remaining != 0)`.
  - `in_fifo_wdata` = `src_data`.
  - Each transfer decrements `remaining` and increments `rsp_count`.
  - The last transfer moves the state to WAIT_DONE.
- STREAM_OUT (all combinational):
  - `snk_valid` = `out_fifo_rempty_n & (remaining != 0)`.
  - `out_fifo_deq` = `snk_valid & snk_ready`.
  - `snk_data` = `out_fifo_rdata`.
  - Counting and exit work as in STREAM_IN.
- Done detection:
  - `done_q` registers the done selected by op.
  - A rise (`done & ~done_q`) from the cycle after PULSE onward sets `done_seen`.
  - A done that is already high (stale from a prior op) is ignored until it falls and rises again.
- WAIT_DONE → RESP when `done_seen` = 1, or after `TIMEOUT_CYC` cycles in WAIT_DONE.
  - On timeout, `rsp_err` = 1.
  - If both occur in the same cycle, `done_seen` wins (`rsp_err` = 0).
- RESP: `rsp_valid` = 1 for one cycle, then IDLE.
- `rsp_err` and `rsp_count` hold their values until the next accept.
- Reset values:
  - All outputs are 0 except `cmd_ready` = 1.
  - State IDLE; all counters and `done_seen` cleared.
  - Assertion mid-operation drops strobes, `wenq` and `deq` immediately and discards the command.
- Stream outputs (`src_ready`, `snk_valid`, `in_fifo_wenq`, `out_fifo_deq`) are forced low outside their streaming states.

## Timing
- Accept on edge T:
  - Strobe is high for exactly cycle T+1.
  - First FIFO transfer is possible in cycle T+2.
- Reserved op: `rsp_valid` in cycle T+1.
- Throughput: one word per cycle when the chip FIFO is not full/empty and src/snk are ready. There are no bubbles.
- Done rise sampled at edge D → RESP in the cycle after D → IDLE (`cmd_ready`) the cycle after that.
- Strobes, `rsp_*` and `busy` are registered. FIFO handshake outputs are combinational from the state and the flow-control inputs.

## Structure
- Package `gpio_host_pkg` holds:
  - the op encodings `OP_LOAD`/`OP_RUN`/`OP_SEND`/`OP_RSVD`;
  - the state enum;
  - the default `WORD_W` = 11.
- Single module with no sub-module. The timeout counter and done edge detector stay inline.

## Test plan
- Reset: hold `rst_n` low, release → all outputs 0, `cmd_ready` = 1, `busy` = 0.
- LOAD, len 5, source data 0x001..0x005, `wfull_n` low for 2 cycles mid-burst:
  - Exactly 5 `wenq`, in order, none while full.
  - `load_kdtree` high for 1 cycle.
  - `load_done` rise → `rsp_valid` with `rsp_err` = 0, `rsp_count` = 5.
- SEND, len 4, with `rempty_n` toggling and `snk_ready` stalling:
  - 4 `deq`, and `snk_data` equals `rdata` on each.
  - No `deq` while empty or stalled.
  - `send_done` rise → `rsp_count` = 4.
- RUN with `fsm_done` already high:
  - No completion until it falls and rises again.
  - Separate run with `TIMEOUT_CYC` = 16 and no rise → `rsp_err` = 1 after exactly 16 WAIT_DONE cycles.
- `cmd_op` = 3 → no strobe; `rsp_valid` with `rsp_err` = 1 in cycle T+1; `rsp_count` = 0.
- Assert `rst_n` after 2 of 6 LOAD words → `wenq` low immediately; after release the state is IDLE and a new command is accepted normally.
